// File: rtl/exec_seq_if.sv
// Fetch handshake and datapath-facing signals of the exec_seq sequencer.
// The perf counter signals exist only when EXEC_SEQ_PERF_EN is defined.
interface exec_seq_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        idu_wen;
    logic        illegal;
    logic        gpr_wen;
    logic        busy;
    logic        halt;
    logic [1:0]  halt_code;
`ifdef EXEC_SEQ_PERF_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    modport master (
        output ifu_req, ifu_addr, inst, pc, gpr_wen, busy, halt, halt_code,
`ifdef EXEC_SEQ_PERF_EN
        output perf_cycle, perf_instret,
`endif
        input  ifu_ack, ifu_rdata, next_pc, idu_wen, illegal
    );

    modport slave (
        input  ifu_req, ifu_addr, inst, pc, gpr_wen, busy, halt, halt_code,
`ifdef EXEC_SEQ_PERF_EN
        input  perf_cycle, perf_instret,
`endif
        output ifu_ack, ifu_rdata, next_pc, idu_wen, illegal
    );
endinterface

// File: rtl/exec_seq.sv
// Multi-cycle BOOT/FETCH/EXEC/WB/HALT sequencer for the NPC datapath.
// Optional perf counters are compiled in with EXEC_SEQ_PERF_EN.
module exec_seq #(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter int unsigned FETCH_TIMEOUT = 255,
    parameter logic [31:0] EBREAK_INST   = 32'h00100073
) (
    input  logic       clk,
    input  logic       rst,
    exec_seq_if.master bus
);
    localparam logic [31:0] NOP_INST     = 32'h00000013;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_halt_code;
    logic [1:0]  w_next_code;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [7:0]  r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_halt_code <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_halt_code <= w_next_code;
        end
    end

    // An ack in the final allowed FETCH cycle takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_halt_code;
        case (r_state)
            S_BOOT:  w_next_state = S_FETCH;
            S_FETCH: begin
                if (bus.ifu_ack) begin
                    w_next_state = S_EXEC;
                end else if (r_timeout == TIMEOUT_LAST) begin
                    w_next_state = S_HALT;
                    w_next_code  = 2'd2;
                end
            end
            S_EXEC: begin
                if (r_inst == EBREAK_INST) begin
                    w_next_state = S_HALT;
                    w_next_code  = 2'd1;
                end else if (bus.illegal) begin
                    w_next_state = S_HALT;
                    w_next_code  = 2'd3;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_WB:    w_next_state = S_FETCH;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= NOP_INST;
            r_timeout <= 8'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.ifu_ack) begin
                        r_inst    <= bus.ifu_rdata;
                        r_timeout <= 8'd0;
                    end else begin
                        r_timeout <= r_timeout + 8'd1;
                    end
                end
                S_WB:    r_pc <= bus.next_pc;
                default: ;
            endcase
        end
    end

    assign bus.ifu_req   = (r_state == S_FETCH);
    assign bus.ifu_addr  = r_pc;
    assign bus.inst      = r_inst;
    assign bus.pc        = r_pc;
    assign bus.gpr_wen   = (r_state == S_WB) && bus.idu_wen;
    assign bus.busy      = (r_state != S_HALT);
    assign bus.halt      = (r_state == S_HALT);
    assign bus.halt_code = r_halt_code;

`ifdef EXEC_SEQ_PERF_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    // Counters stop in BOOT and HALT, so they freeze once the core parks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycle   <= 64'd0;
            r_perf_instret <= 64'd0;
        end else begin
            if (r_state != S_BOOT && r_state != S_HALT) begin
                r_perf_cycle <= r_perf_cycle + 64'd1;
            end
            if (r_state == S_WB) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign bus.perf_cycle   = r_perf_cycle;
    assign bus.perf_instret = r_perf_instret;
`endif
endmodule

// File: tb/tb_exec_seq.sv
// Self-checking bench for exec_seq: vector table, hand-written corner sequences
// and a randomized instruction stream against a per-instruction reference model.
module tb_exec_seq;
    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] EBREAK   = 32'h00100073;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam int          TIMEOUT  = 255;

    typedef struct {
        int          delay;
        logic [31:0] word;
        logic        iduWen;
        logic        illegal;
        logic [31:0] nextPc;
        logic        staleAck;
        logic [1:0]  expCode;
        logic        expWen;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errCount = 0;
    int          checkCount = 0;
    logic [31:0] expPc;
    logic [31:0] expInst;
    logic [1:0]  expCode;
    longint      modelCycles;
    longint      modelInstret;

    exec_seq_if bus();

    exec_seq #(
        .RESET_PC(RESET_PC),
        .FETCH_TIMEOUT(TIMEOUT),
        .EBREAK_INST(EBREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic [31:0] nextPc,
                                 input logic iduWen, input logic ill);
        bus.ifu_ack   = ack;
        bus.ifu_rdata = rdata;
        bus.next_pc   = nextPc;
        bus.idu_wen   = iduWen;
        bus.illegal   = ill;
    endtask

    task automatic checkPerf(input string tag);
`ifdef EXEC_SEQ_PERF_EN
        checkOutput({tag, "_perf_cycle"}, bus.perf_cycle, 64'(modelCycles));
        checkOutput({tag, "_perf_instret"}, bus.perf_instret, 64'(modelInstret));
`else
        if (tag.len() < 0) $display("[TB] %s", tag);
`endif
    endtask

    // Leaves the bench at the negedge that starts the first FETCH cycle.
    task automatic resetDut();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("boot_req", 64'(bus.ifu_req), 64'd0);
        checkOutput("boot_pc", 64'(bus.pc), 64'(RESET_PC));
        checkOutput("boot_inst", 64'(bus.inst), 64'(NOP));
        checkOutput("boot_busy", 64'(bus.busy), 64'd1);
        checkOutput("boot_halt", 64'({bus.halt, bus.halt_code, bus.gpr_wen}), 64'd0);
        @(negedge clk);
        expPc        = RESET_PC;
        expInst      = NOP;
        expCode      = 2'd0;
        modelCycles  = 0;
        modelInstret = 0;
    endtask

    task automatic runInst(input vec_t v);
        int badCycles = 0;
        for (int c = 0; c <= v.delay; c++) begin
            logic ackNow;
            ackNow = (c == v.delay);
            applyStimulus(ackNow, ackNow ? v.word : $urandom, v.nextPc, 1'b1, 1'b0);
            #1;
            if (bus.ifu_req !== 1'b1 || bus.ifu_addr !== expPc || bus.gpr_wen !== 1'b0 || bus.halt !== 1'b0)
                badCycles++;
            if (c == 0) checkOutput("fetch_inst_held", 64'(bus.inst), 64'(expInst));
            @(negedge clk);
        end
        checkOutput("fetch_stable", 64'(badCycles), 64'd0);
        modelCycles += v.delay + 1;

        applyStimulus(v.staleAck, $urandom, v.nextPc, 1'b1, v.illegal);
        #1;
        checkOutput("exec_req", 64'(bus.ifu_req), 64'd0);
        checkOutput("exec_inst", 64'(bus.inst), 64'(v.word));
        checkOutput("exec_gpr_wen", 64'(bus.gpr_wen), 64'd0);
        checkOutput("exec_pc", 64'(bus.pc), 64'(expPc));
        @(negedge clk);
        modelCycles++;
        expInst = v.word;

        if (v.expCode != 2'd0) begin
            expCode = v.expCode;
            #1;
            checkOutput("halt_flag", 64'(bus.halt), 64'd1);
            checkOutput("halt_code", 64'(bus.halt_code), 64'(v.expCode));
            checkOutput("halt_busy", 64'(bus.busy), 64'd0);
            checkOutput("halt_pc", 64'(bus.pc), 64'(expPc));
            checkOutput("halt_gpr_wen", 64'(bus.gpr_wen), 64'd0);
            checkPerf("halt");
            return;
        end

        applyStimulus(v.staleAck, $urandom, v.nextPc, v.iduWen, 1'($urandom_range(0, 1)));
        #1;
        checkOutput("wb_gpr_wen", 64'(bus.gpr_wen), 64'(v.expWen));
        checkOutput("wb_state", 64'({bus.ifu_req, bus.halt, bus.busy}), 64'b001);
        checkOutput("wb_pc", 64'(bus.pc), 64'(expPc));
        @(negedge clk);
        modelCycles++;
        modelInstret++;
        expPc = v.nextPc;
    endtask

    task automatic holdHalt(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, 1'($urandom_range(0, 1)));
            #1;
            checkOutput("hold_status", 64'({bus.halt, bus.busy, bus.ifu_req, bus.gpr_wen}), 64'b1000);
            checkOutput("hold_code", 64'(bus.halt_code), 64'(expCode));
            checkOutput("hold_pc", 64'(bus.pc), 64'(expPc));
            checkOutput("hold_inst", 64'(bus.inst), 64'(expInst));
            checkPerf("hold");
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   stable;

        // Straight run with delays, a stale ack, pc wrap, ack-on-timeout-edge and a final ebreak.
        vecs[0] = '{0,   32'h00500093, 1'b1, 1'b0, 32'h80000004, 1'b0, 2'd0, 1'b1};
        vecs[1] = '{3,   32'h00a00113, 1'b1, 1'b0, 32'h80000008, 1'b1, 2'd0, 1'b1};
        vecs[2] = '{1,   32'h00000013, 1'b0, 1'b0, 32'hfffffffc, 1'b1, 2'd0, 1'b0};
        vecs[3] = '{0,   32'h00000093, 1'b1, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{254, 32'h12345093, 1'b1, 1'b0, 32'h00000004, 1'b1, 2'd0, 1'b1};
        vecs[5] = '{2,   EBREAK,       1'b1, 1'b1, 32'hdeadbeef, 1'b1, 2'd1, 1'b0};

        resetDut();
        for (int i = 0; i < 6; i++) runInst(vecs[i]);
        holdHalt(4);

        // Illegal instruction halts, then an asynchronous reset between clock edges.
        resetDut();
        v = '{0, 32'h0000007f, 1'b1, 1'b1, 32'h80000004, 1'b0, 2'd3, 1'b0};
        runInst(v);
        holdHalt(2);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pc", 64'(bus.pc), 64'(RESET_PC));
        checkOutput("async_rst_inst", 64'(bus.inst), 64'(NOP));
        checkOutput("async_rst_status", 64'({bus.halt, bus.halt_code, bus.busy, bus.ifu_req}), 64'b00010);

        // Reset mid-FETCH, then a fetch that never gets an ack.
        resetDut();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midfetch_rst_req", 64'(bus.ifu_req), 64'd0);
        resetDut();
        stable = 0;
        for (int c = 0; c < TIMEOUT; c++) begin
            applyStimulus(1'b0, $urandom, $urandom, 1'b1, 1'b0);
            #1;
            if (bus.ifu_req !== 1'b1 || bus.ifu_addr !== RESET_PC || bus.halt !== 1'b0) stable++;
            @(negedge clk);
        end
        checkOutput("timeout_wait_stable", 64'(stable), 64'd0);
        modelCycles += TIMEOUT;
        expCode = 2'd2;
        #1;
        checkOutput("timeout_halt", 64'({bus.halt, bus.halt_code}), 64'b110);
        holdHalt(2);

        // Ten single-cycle-ack instructions then ebreak: perf totals are 32 cycles / 10 retired.
        resetDut();
        for (int i = 0; i < 10; i++) begin
            v = '{0, 32'h00500093, 1'b1, 1'b0, expPc + 32'd4, 1'b0, 2'd0, 1'b1};
            runInst(v);
        end
        v = '{0, EBREAK, 1'b1, 1'b0, expPc + 32'd4, 1'b0, 2'd1, 1'b0};
        runInst(v);
        checkOutput("perf_model_cycles", 64'(modelCycles), 64'd32);
        checkOutput("perf_model_instret", 64'(modelInstret), 64'd10);
        holdHalt(3);

        // Randomized stream: expectations follow the instruction-level rules only.
        resetDut();
        for (int i = 0; i < 30; i++) begin
            v.delay    = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 20) : $urandom_range(0, 5);
            v.word     = $urandom;
            if (v.word == EBREAK) v.word = v.word ^ 32'h1;
            v.iduWen   = 1'($urandom_range(0, 1));
            v.illegal  = 1'b0;
            v.nextPc   = $urandom;
            v.staleAck = 1'($urandom_range(0, 1));
            v.expCode  = 2'd0;
            v.expWen   = v.iduWen;
            runInst(v);
        end
        v.delay    = $urandom_range(0, 4);
        v.illegal  = 1'($urandom_range(0, 1));
        v.word     = ($urandom_range(0, 1) == 1) ? EBREAK : 32'h0000707f;
        if (v.word != EBREAK) v.illegal = 1'b1;
        v.iduWen   = 1'b1;
        v.nextPc   = $urandom;
        v.staleAck = 1'($urandom_range(0, 1));
        v.expCode  = (v.word == EBREAK) ? 2'd1 : 2'd3;
        v.expWen   = 1'b0;
        runInst(v);
        holdHalt(3);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/exec_seq.md
Name: exec_seq

Overview:
- Multi-cycle sequencer for the NPC single-cycle datapath (PC, IFU, IDU, GPR, ALU, IMM).
- Fetches each instruction through a req/ack handshake and holds it stable for the decode/execute cycle.
- Gates the GPR write enable and the PC update to a single write-back cycle per instruction.
- Detects ebreak, illegal instructions and fetch timeout, and parks the core in a sticky HALT.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- FETCH_TIMEOUT, 255, maximum number of FETCH cycles without ack before halting; valid range 1..255.
- EBREAK_INST, 32'h00100073, encoding that triggers a clean halt.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- ifu_req  output  1  fetch request, held until ack.
- ifu_addr  output  32  fetch address, equals pc.
- ifu_ack  input  1  fetch data valid this cycle.
- ifu_rdata  input  32  fetched instruction.
- inst  output  32  latched instruction, drives IDU/IMM/GPR address fields.
- pc  output  32  current PC.
- next_pc  input  32  PC of the next instruction, computed by the datapath.
- idu_wen  input  1  decoder's register-write request.
- illegal  input  1  decoder flags an unsupported opcode.
- gpr_wen  output  1  gated GPR write enable.
- busy  output  1  high in every state except HALT.
- halt  output  1  sticky halt flag.
- halt_code  output  2  halt cause: 0 none, 1 ebreak, 2 fetch timeout, 3 illegal.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high. All state is in registers on the rising edge of `clk`, cleared asynchronously by `rst`.
- Reset values:
  - state = BOOT, pc = RESET_PC, inst = 32'h00000013 (nop).
  - ifu_req = 0, gpr_wen = 0, halt = 0, halt_code = 0.
  - timeout counter = 0, busy = 1.
- States and outputs:
  - BOOT: one cycle with ifu_req = 0, then goes to FETCH.
  - FETCH: ifu_req = 1, ifu_addr = pc. The request and address stay stable until ifu_ack is seen.
    - On ack, inst <= ifu_rdata, the counter clears, and the next state is EXEC.
    - Without ack, the counter increments. When the counter reaches FETCH_TIMEOUT-1 with no ack, the next state is HALT with code 2.
  - EXEC: ifu_req = 0, inst is held. Checks in priority order:
    - inst == EBREAK_INST: go to HALT, code 1.
    - else illegal: go to HALT, code 3.
    - else: go to WB.
  - WB: gpr_wen = idu_wen for exactly this cycle, pc <= next_pc at the end of the cycle, then go to FETCH.
  - HALT: absorbing state. halt = 1, busy = 0, gpr_wen = 0, ifu_req = 0. pc and inst are frozen at the halting instruction. Only rst leaves HALT.
- gpr_wen timing: gpr_wen is combinational from state and idu_wen, and is never high outside WB.
- Latency: minimum 3 cycles per instruction (FETCH with same-cycle ack, EXEC, WB). Each extra cycle of ack delay adds 1 cycle.
- Handshake rules:
  - ifu_ack is ignored outside FETCH.
  - ifu_req never drops while waiting in FETCH.
  - A stale ack arriving in EXEC or WB is discarded and does not advance the FSM.
- Boundary conditions:
  - Ack on the same cycle the timeout would fire: the ack wins.
  - pc wraps modulo 2^32 with no special handling.
  - A halting instruction performs no GPR write and no PC update.
  - rst asserted in any state, including mid-FETCH or HALT, immediately returns all registers to their reset values.

Optional Feature:
- Macro: EXEC_SEQ_PERF_EN.
- Defined: adds two ports.
  - perf_cycle, output 64: counts every cycle in which state is not BOOT and not HALT.
  - perf_instret, output 64: increments once per WB cycle.
  - Both reset to 0 and freeze in HALT.
- Undefined: neither port nor their registers exist; all other behaviour is identical.

Test Plan:
- Reset release, memory acks every request immediately with addi x1,x0,5 (32'h00500093), idu_wen = 1, next_pc = pc + 4:
  - ifu_req is 0 during BOOT, then 1 with ifu_addr = 32'h80000000.
  - gpr_wen pulses high for exactly 1 cycle, 2 cycles after the ack.
  - pc is 32'h80000004 on the following FETCH.
- Ack delayed 3 cycles:
  - ifu_req and ifu_addr are stable for 4 cycles, and the instruction completes in 6 cycles.
  - A spurious ack in EXEC is ignored (no double advance).
- Fetch ebreak (32'h00100073):
  - No gpr_wen pulse; halt = 1 and halt_code = 1 two cycles after the ack.
  - pc stays at the ebreak address and busy = 0.
- Ack never arrives:
  - After 255 FETCH cycles, halt = 1 with halt_code = 2.
- illegal = 1 in EXEC:
  - halt_code = 3 and pc is unchanged.
  - Asserting rst afterwards returns pc to 32'h80000000, halt to 0 and inst to 32'h00000013, asynchronously (before the next clock edge).
- With EXEC_SEQ_PERF_EN, 10 instructions of 3 cycles each, then ebreak:
  - perf_instret = 10 and perf_cycle = 32 (30 + 2 for ebreak).
  - Both values hold steady in HALT.
